// File: rtl/tqv_debug_uart_pkg.sv
// tqv_debug_uart_pkg
//    Shared constants for the tinyQV debug UART: register select codes,
//    STATUS bit positions, TX/RX state encodings and the divisor helper.
//    No ports (package).

package tqv_debug_uart_pkg;

   // Register select codes (reg_sel)
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   // STATUS bit indices
   localparam int ST_TX_BUSY   = 0;
   localparam int ST_TX_FULL   = 1;
   localparam int ST_TX_OVF    = 2;
   localparam int ST_RX_VALID  = 3;
   localparam int ST_RX_OVR    = 4;
   localparam int ST_RX_FERR   = 5;
   localparam int ST_LEVEL_LSB = 8;

   // Transmitter state encoding
   typedef logic [1:0] tx_state_t;
   localparam tx_state_t TX_IDLE  = 2'd0;
   localparam tx_state_t TX_START = 2'd1;
   localparam tx_state_t TX_DATA  = 2'd2;
   localparam tx_state_t TX_STOP  = 2'd3;

   // Receiver state encoding
   typedef logic [1:0] rx_state_t;
   localparam rx_state_t RX_IDLE  = 2'd0;
   localparam rx_state_t RX_START = 2'd1;
   localparam rx_state_t RX_DATA  = 2'd2;
   localparam rx_state_t RX_STOP  = 2'd3;

   // A divisor of 0 would mean 1-cycle bits; it is promoted to 1 (2-cycle bits).
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/tqv_debug_uart_if.sv
// tqv_debug_uart_if
//    tinyQV peripheral data-bus bundle for the debug UART.
//    Signals: reg_sel[1:0], sel, data_in[31:0], data_write_n[1:0],
//             data_read_n[1:0], data_read_complete (CPU -> peripheral)
//             data_out[31:0], data_ready (peripheral -> CPU)
//    Modports: master (CPU side), slave (peripheral side).

interface tqv_debug_uart_if;
   logic [1:0]  reg_sel;
   logic        sel;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic        data_read_complete;
   logic [31:0] data_out;
   logic        data_ready;

   modport master (
      output reg_sel, sel, data_in, data_write_n, data_read_n, data_read_complete,
      input  data_out, data_ready
   );

   modport slave (
      input  reg_sel, sel, data_in, data_write_n, data_read_n, data_read_complete,
      output data_out, data_ready
   );
endinterface

// File: rtl/tqv_byte_fifo.sv
// tqv_byte_fifo
//    Synchronous 8-bit FIFO with occupancy count. A push while full is
//    accepted only when a pop happens in the same cycle.
//    Ports: clk, rst_n (sync active-low), push, pop, wr_data[7:0],
//           rd_data[7:0] (head entry, combinational), full, empty,
//           level[$clog2(DEPTH):0]
//    Parameter: DEPTH (power of 2, >= 2)

module tqv_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [7:0]             wr_data,
   output logic [7:0]             rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   level_r;
   logic          push_ok_s;
   logic          pop_ok_s;
   logic          full_s;
   logic          empty_s;

   assign full_s    = (level_r == (AW+1)'(DEPTH));
   assign empty_s   = (level_r == '0);
   assign pop_ok_s  = pop & ~empty_s;
   assign push_ok_s = push & (~full_s | pop_ok_s);

   assign full    = full_s;
   assign empty   = empty_s;
   assign level   = level_r;
   assign rd_data = mem_r[rd_ptr_r];

   // Storage write; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + (AW+1)'(1'b1);
            2'b01:   level_r <= level_r - (AW+1)'(1'b1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/tqv_debug_uart.sv
// tqv_debug_uart
//    Memory-mapped debug UART for tinyQV: TX FIFO, runtime baud divisor,
//    sticky error flags, interrupts, optional receiver.
//    Ports: clk, rst_n (sync active-low), bus (tqv_debug_uart_if.slave),
//           uart_txd (idle high), uart_rxd (async), irq[1:0]
//           irq[0] = TX FIFO empty and shifter idle, irq[1] = RX byte valid
//    Registers: 0 DATA, 1 STATUS, 2 DIV (clocks-per-bit minus 1), 3 reserved
//    Build option: define DEBUG_UART_RX_EN to include the receiver.

module tqv_debug_uart
   import tqv_debug_uart_pkg::*;
#(
   parameter int CLK_HZ   = 14_000_000,
   parameter int BIT_RATE = 1_000_000,
   parameter int TX_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   tqv_debug_uart_if.slave  bus,
   output logic             uart_txd,
   input  logic             uart_rxd,
   output logic [1:0]       irq
);
   localparam int          LW      = $clog2(TX_DEPTH) + 1;
   localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BIT_RATE - 1);

   // Bus decode
   logic wr_en_s, data_wr_s, status_wr_s, div_wr_s;
   assign wr_en_s     = bus.sel & (bus.data_write_n != 2'b11);
   assign data_wr_s   = wr_en_s & (bus.reg_sel == REG_DATA);
   assign status_wr_s = wr_en_s & (bus.reg_sel == REG_STATUS);
   assign div_wr_s    = wr_en_s & (bus.reg_sel == REG_DIV);

   logic bus_unused_s;
   assign bus_unused_s = ^{bus.data_read_n, bus.data_in[31:16]};

   // Divisor register
   logic [15:0] div_r;

   // Runtime divisor; the shifters latch their own copy at frame start.
   always_ff @(posedge clk) begin
      if (!rst_n)        div_r <= DIV_RST;
      else if (div_wr_s) div_r <= bus.data_in[15:0];
   end

   // TX FIFO
   logic          fifo_pop_s, fifo_full_s, fifo_empty_s;
   logic [7:0]    fifo_rd_data_s;
   logic [LW-1:0] fifo_level_s;

   tqv_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (data_wr_s),
      .pop     (fifo_pop_s),
      .wr_data (bus.data_in[7:0]),
      .rd_data (fifo_rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .level   (fifo_level_s)
   );

   // TX shifter
   tx_state_t   tx_state_r;
   logic [15:0] tx_cnt_r;
   logic [15:0] tx_div_r;
   logic [2:0]  tx_bit_r;
   logic [7:0]  tx_shreg_r;
   logic        tx_txd_r;
   logic        tx_bit_end_s;
   logic        tx_idle_s;

   assign tx_bit_end_s = (tx_cnt_r == tx_div_r);
   assign tx_idle_s    = (tx_state_r == TX_IDLE);
   // Popping at the end of a stop bit chains frames with no idle gap.
   assign fifo_pop_s   = ~fifo_empty_s &
                         (tx_idle_s | ((tx_state_r == TX_STOP) & tx_bit_end_s));

   // TX frame sequencer: start bit, 8 data bits LSB first, stop bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= 16'd0;
         tx_div_r   <= 16'd0;
         tx_bit_r   <= 3'd0;
         tx_shreg_r <= 8'd0;
         tx_txd_r   <= 1'b1;
      end else begin
         case (tx_state_r)
            TX_IDLE: begin
               if (fifo_pop_s) begin
                  tx_state_r <= TX_START;
                  tx_cnt_r   <= 16'd0;
                  tx_div_r   <= eff_div(div_r);
                  tx_shreg_r <= fifo_rd_data_s;
                  tx_txd_r   <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_bit_end_s) begin
                  tx_state_r <= TX_DATA;
                  tx_cnt_r   <= 16'd0;
                  tx_bit_r   <= 3'd0;
                  tx_txd_r   <= tx_shreg_r[0];
               end else begin
                  tx_cnt_r <= tx_cnt_r + 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_bit_end_s) begin
                  tx_cnt_r <= 16'd0;
                  if (tx_bit_r == 3'd7) begin
                     tx_state_r <= TX_STOP;
                     tx_txd_r   <= 1'b1;
                  end else begin
                     tx_bit_r   <= tx_bit_r + 3'd1;
                     tx_shreg_r <= {1'b0, tx_shreg_r[7:1]};
                     tx_txd_r   <= tx_shreg_r[1];
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_bit_end_s) begin
                  tx_cnt_r <= 16'd0;
                  if (fifo_pop_s) begin
                     tx_state_r <= TX_START;
                     tx_div_r   <= eff_div(div_r);
                     tx_shreg_r <= fifo_rd_data_s;
                     tx_txd_r   <= 1'b0;
                  end else begin
                     tx_state_r <= TX_IDLE;
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + 16'd1;
               end
            end
            default: begin
               tx_state_r <= TX_IDLE;
               tx_txd_r   <= 1'b1;
            end
         endcase
      end
   end

   assign uart_txd = tx_txd_r;

   // TX overflow flag
   logic tx_ovf_r;
   logic tx_drop_s;
   assign tx_drop_s = data_wr_s & fifo_full_s & ~fifo_pop_s;

   // Sticky overflow: a fresh drop wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst_n)                                      tx_ovf_r <= 1'b0;
      else if (tx_drop_s)                              tx_ovf_r <= 1'b1;
      else if (status_wr_s && bus.data_in[ST_TX_OVF])  tx_ovf_r <= 1'b0;
   end

   // Receiver
   logic       rx_valid_s;
   logic       rx_ovr_s;
   logic       rx_ferr_s;
   logic [7:0] rx_data_s;

`ifdef DEBUG_UART_RX_EN
   rx_state_t   rx_state_r;
   logic        rx_meta_r, rx_sync_r, rx_prev_r;
   logic [15:0] rx_cnt_r;
   logic [15:0] rx_div_r;
   logic [15:0] rx_half_s;
   logic [2:0]  rx_bit_r;
   logic [7:0]  rx_shreg_r;
   logic [7:0]  rx_data_r;
   logic        rx_valid_r, rx_ovr_r, rx_ferr_r;
   logic        rx_stop_smp_s, rx_good_s, rx_bad_s, rx_rd_done_s;

   assign rx_half_s     = 16'(({1'b0, rx_div_r} + 17'd1) >> 1);
   assign rx_stop_smp_s = (rx_state_r == RX_STOP) & (rx_cnt_r == rx_div_r);
   assign rx_good_s     = rx_stop_smp_s & rx_sync_r;
   assign rx_bad_s      = rx_stop_smp_s & ~rx_sync_r;
   assign rx_rd_done_s  = bus.sel & bus.data_read_complete & (bus.reg_sel == REG_DATA);

   // RX line synchroniser and frame sampler (mid-bit sampling).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_r  <= 1'b1;
         rx_sync_r  <= 1'b1;
         rx_prev_r  <= 1'b1;
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= 16'd0;
         rx_div_r   <= 16'd1;
         rx_bit_r   <= 3'd0;
         rx_shreg_r <= 8'd0;
      end else begin
         rx_meta_r <= uart_rxd;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
         case (rx_state_r)
            RX_IDLE: begin
               if (rx_prev_r && !rx_sync_r) begin
                  rx_state_r <= RX_START;
                  rx_cnt_r   <= 16'd0;
                  rx_div_r   <= eff_div(div_r);
               end
            end
            RX_START: begin
               // Re-check the start bit half a bit in; a glitch returns to idle.
               if (rx_cnt_r == rx_half_s) begin
                  rx_cnt_r   <= 16'd0;
                  rx_bit_r   <= 3'd0;
                  rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_r <= rx_cnt_r + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_r == rx_div_r) begin
                  rx_cnt_r   <= 16'd0;
                  rx_shreg_r <= {rx_sync_r, rx_shreg_r[7:1]};
                  if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
                  else                  rx_bit_r   <= rx_bit_r + 3'd1;
               end else begin
                  rx_cnt_r <= rx_cnt_r + 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_r == rx_div_r) rx_state_r <= RX_IDLE;
               else                      rx_cnt_r   <= rx_cnt_r + 16'd1;
            end
            default: rx_state_r <= RX_IDLE;
         endcase
      end
   end

   // Holding register and RX flags; a read completing this cycle frees the slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data_r  <= 8'd0;
         rx_valid_r <= 1'b0;
         rx_ovr_r   <= 1'b0;
         rx_ferr_r  <= 1'b0;
      end else begin
         if (rx_good_s) begin
            if (rx_valid_r && !rx_rd_done_s) begin
               rx_ovr_r <= 1'b1;
            end else begin
               rx_data_r  <= rx_shreg_r;
               rx_valid_r <= 1'b1;
            end
         end else if (rx_rd_done_s) begin
            rx_valid_r <= 1'b0;
         end
         if (rx_good_s && rx_valid_r && !rx_rd_done_s) rx_ovr_r <= 1'b1;
         else if (status_wr_s && bus.data_in[ST_RX_OVR]) rx_ovr_r <= 1'b0;
         if (rx_bad_s) rx_ferr_r <= 1'b1;
         else if (status_wr_s && bus.data_in[ST_RX_FERR]) rx_ferr_r <= 1'b0;
      end
   end

   assign rx_valid_s = rx_valid_r;
   assign rx_ovr_s   = rx_ovr_r;
   assign rx_ferr_s  = rx_ferr_r;
   assign rx_data_s  = rx_data_r;
`else
   logic rx_unused_s;
   assign rx_unused_s = uart_rxd ^ bus.data_read_complete;
   assign rx_valid_s  = 1'b0;
   assign rx_ovr_s    = 1'b0;
   assign rx_ferr_s   = 1'b0;
   assign rx_data_s   = 8'd0;
`endif

   // Read mux and interrupts
   logic        tx_busy_s;
   logic [31:0] status_s;
   logic [31:0] data_out_s;

   assign tx_busy_s = ~fifo_empty_s | ~tx_idle_s;

   // STATUS word assembly.
   always_comb begin
      status_s                          = 32'h0;
      status_s[ST_TX_BUSY]              = tx_busy_s;
      status_s[ST_TX_FULL]              = fifo_full_s;
      status_s[ST_TX_OVF]               = tx_ovf_r;
      status_s[ST_RX_VALID]             = rx_valid_s;
      status_s[ST_RX_OVR]               = rx_ovr_s;
      status_s[ST_RX_FERR]              = rx_ferr_s;
      status_s[ST_LEVEL_LSB+7:ST_LEVEL_LSB] = 8'(fifo_level_s);
   end

   // Combinational register read mux.
   always_comb begin
      data_out_s = 32'hFFFF_FFFF;
      case (bus.reg_sel)
         REG_DATA:   data_out_s = {24'h0, rx_data_s};
         REG_STATUS: data_out_s = status_s;
         REG_DIV:    data_out_s = {16'h0, div_r};
         default:    data_out_s = 32'hFFFF_FFFF;
      endcase
   end

   assign bus.data_out   = data_out_s;
   assign bus.data_ready = 1'b1;
   assign irq            = {rx_valid_s, ~tx_busy_s};

endmodule
